// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receive controller.
//
// Contents:
//   DEFAULT_DATA_WIDTH     - default number of data bits per frame
//   PRESC_8/16/32          - the oversampling ratios the receiver accepts
//   rx_state_t             - receiver FSM state encoding
//   sanitize_prescale()    - maps an unsupported ratio onto PRESC_8
//
// Build option: UART_RX_BREAK_DET_EN adds the BREAK state to rx_state_t.

package uart_rx_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        VALID
`ifdef UART_RX_BREAK_DET_EN
        , BREAK
`endif
    } rx_state_t;

    function automatic int unsigned sanitize_prescale(input int unsigned p);
        if (p == PRESC_8 || p == PRESC_16 || p == PRESC_32) begin
            return p;
        end
        return PRESC_8;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial line, frame configuration and result signals of
// the UART receive controller.
//
// Signals:
//   rx_in        - serial line, idle high, already synchronised
//   PAR_EN       - parity bit present
//   PAR_TYP      - 0 = even parity, 1 = odd parity
//   STOP2        - 1 = two stop bits, 0 = one stop bit
//   prescale     - oversampling ratio (8, 16 or 32)
//   P_DATA       - last correctly received word
//   data_valid   - one-cycle pulse for a good frame
//   par_err      - one-cycle parity error pulse
//   stp_err      - one-cycle stop bit error pulse
//   strt_glitch  - one-cycle pulse for a rejected start bit
//   break_det    - one-cycle line break pulse
//   busy         - receiver is not idle
//
// Modports: master drives the line and configuration, slave is the receiver.

interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = uart_rx_pkg::DEFAULT_DATA_WIDTH,
    parameter int PRESC_W    = 6
);

    logic                  rx_in;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [PRESC_W-1:0]    prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;
    logic                  break_det;
    logic                  busy;

    modport master (
        output rx_in, PAR_EN, PAR_TYP, STOP2, prescale,
        input  P_DATA, data_valid, par_err, stp_err, strt_glitch, break_det, busy
    );

    modport slave (
        input  rx_in, PAR_EN, PAR_TYP, STOP2, prescale,
        output P_DATA, data_valid, par_err, stp_err, strt_glitch, break_det, busy
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 3-sample majority voter and edge-position decode.
//
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   rx_in       - serial line
//   edge_cnt    - position inside the current bit period (0..presc-1)
//   presc       - captured oversampling ratio
//   sample_bit  - majority of the samples taken at presc/2-1, presc/2, presc/2+1
//   vote_edge   - edge_cnt == presc/2+2, the first position where sample_bit
//                 reflects all three samples of the current bit
//   last_edge   - edge_cnt == presc-1, the final position of a bit period

module uart_rx_sampler #(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic [PRESC_W-1:0] presc,
    output logic               sample_bit,
    output logic               vote_edge,
    output logic               last_edge
);

    logic [PRESC_W-1:0] half;
    logic [2:0]         samples;

    assign half = presc >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samples <= '0;
        end else begin
            if (edge_cnt == half - PRESC_W'(1)) samples[0] <= rx_in;
            if (edge_cnt == half)               samples[1] <= rx_in;
            if (edge_cnt == half + PRESC_W'(1)) samples[2] <= rx_in;
        end
    end

    assign sample_bit = (samples[0] & samples[1]) |
                        (samples[0] & samples[2]) |
                        (samples[1] & samples[2]);

    assign vote_edge = (edge_cnt == half + PRESC_W'(2));
    assign last_edge = (edge_cnt == presc - PRESC_W'(1));

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receive controller.
//
// Ports:
//   clk   - single clock
//   rst   - asynchronous active-low reset
//   bus   - uart_rx_ctrl_if.slave: serial line, frame configuration,
//           received word, result pulses and busy
//
// Parameters:
//   DATA_WIDTH - data bits per frame (5..9)
//   PRESC_W    - width of the prescale input
//
// Build option: define UART_RX_BREAK_DET_EN to report an all-zero frame with
// a bad stop bit as break_det and to wait in BREAK until the line goes high.
// Without it break_det stays 0 and such frames report stp_err.

module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PRESC_W    = 6
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_ctrl_if.slave  bus
);

    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    rx_state_t             state;
    logic [PRESC_W-1:0]    edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] p_data_q;

    logic                  cfg_par_en;
    logic                  cfg_par_typ;
    logic                  cfg_stop2;
    logic [PRESC_W-1:0]    cfg_presc;

    logic                  par_flag;
    logic                  stp_flag;

    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic                  strt_glitch_q;
    logic                  break_det_q;

    logic                  sample_bit;
    logic                  vote_edge;
    logic                  last_edge;
    logic                  start_req;
    logic                  frame_end;

`ifdef UART_RX_BREAK_DET_EN
    logic                  par_bit;
    logic                  frame_zero;

    // A break looks like a frame whose every bit, parity included, is 0.
    assign frame_zero = (shift_reg == '0) && !(cfg_par_en && par_bit);
`endif

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (bus.rx_in),
        .edge_cnt   (edge_cnt),
        .presc      (cfg_presc),
        .sample_bit (sample_bit),
        .vote_edge  (vote_edge),
        .last_edge  (last_edge)
    );

    // A new frame can begin from IDLE or straight out of VALID (back-to-back).
    assign start_req = !bus.rx_in && (state == IDLE || state == VALID);

    // The last stop bit ends either STOP1 (one stop bit) or STOP2.
    assign frame_end = last_edge &&
                       ((state == STOP1 && !cfg_stop2) || state == STOP2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            edge_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            p_data_q      <= '0;
            cfg_par_en    <= 1'b0;
            cfg_par_typ   <= 1'b0;
            cfg_stop2     <= 1'b0;
            cfg_presc     <= PRESC_W'(PRESC_8);
            par_flag      <= 1'b0;
            stp_flag      <= 1'b0;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            strt_glitch_q <= 1'b0;
            break_det_q   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit       <= 1'b0;
`endif
        end else begin
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            strt_glitch_q <= 1'b0;
            break_det_q   <= 1'b0;

            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                end

                START: begin
                    if (vote_edge && sample_bit) begin
                        state         <= IDLE;
                        strt_glitch_q <= 1'b1;
                        edge_cnt      <= '0;
                    end else if (last_edge) begin
                        state    <= DATA;
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        edge_cnt <= edge_cnt + PRESC_W'(1);
                    end
                end

                DATA: begin
                    // LSB arrives first, so shift in from the top.
                    if (vote_edge) begin
                        shift_reg <= {sample_bit, shift_reg[DATA_WIDTH-1:1]};
                    end
                    if (last_edge) begin
                        edge_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= cfg_par_en ? PARITY : STOP1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        edge_cnt <= edge_cnt + PRESC_W'(1);
                    end
                end

                PARITY: begin
                    if (vote_edge) begin
                        par_flag <= (sample_bit != ((^shift_reg) ^ cfg_par_typ));
`ifdef UART_RX_BREAK_DET_EN
                        par_bit  <= sample_bit;
`endif
                    end
                    if (last_edge) begin
                        edge_cnt <= '0;
                        state    <= STOP1;
                    end else begin
                        edge_cnt <= edge_cnt + PRESC_W'(1);
                    end
                end

                STOP1: begin
                    if (vote_edge && !sample_bit) stp_flag <= 1'b1;
                    if (last_edge) begin
                        edge_cnt <= '0;
                        if (cfg_stop2) state <= STOP2;
                    end else begin
                        edge_cnt <= edge_cnt + PRESC_W'(1);
                    end
                end

                STOP2: begin
                    if (vote_edge && !sample_bit) stp_flag <= 1'b1;
                    if (last_edge) begin
                        edge_cnt <= '0;
                    end else begin
                        edge_cnt <= edge_cnt + PRESC_W'(1);
                    end
                end

                VALID: begin
                    state <= IDLE;
                end

`ifdef UART_RX_BREAK_DET_EN
                BREAK: begin
                    if (bus.rx_in) state <= IDLE;
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase

            // Results are decided once the last stop bit period completes;
            // the flags read here were set at earlier vote positions.
            if (frame_end) begin
                if (!par_flag && !stp_flag) begin
                    state        <= VALID;
                    p_data_q     <= shift_reg;
                    data_valid_q <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                end else if (stp_flag && frame_zero) begin
                    state       <= BREAK;
                    break_det_q <= 1'b1;
`endif
                end else begin
                    state     <= IDLE;
                    par_err_q <= par_flag;
                    stp_err_q <= stp_flag;
                end
            end

            // Frame settings are frozen here so mid-frame input changes
            // cannot disturb bit timing or checking.
            if (start_req) begin
                state       <= START;
                edge_cnt    <= '0;
                bit_cnt     <= '0;
                shift_reg   <= '0;
                par_flag    <= 1'b0;
                stp_flag    <= 1'b0;
                cfg_par_en  <= bus.PAR_EN;
                cfg_par_typ <= bus.PAR_TYP;
                cfg_stop2   <= bus.STOP2;
                cfg_presc   <= PRESC_W'(sanitize_prescale(32'(bus.prescale)));
            end
        end
    end

    assign bus.P_DATA      = p_data_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.par_err     = par_err_q;
    assign bus.stp_err     = stp_err_q;
    assign bus.strt_glitch = strt_glitch_q;
    assign bus.break_det   = break_det_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter PRESC_W, default 6, meaning width of the prescale input.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port rx_in, input, 1 bit: serial line, idle high, already synchronised.
REQ-006 SHALL have port PAR_EN, input, 1 bit: parity bit present.
REQ-007 SHALL have port PAR_TYP, input, 1 bit: 0 = even parity, 1 = odd parity.
REQ-008 SHALL have port STOP2, input, 1 bit: 1 = two stop bits, 0 = one stop bit.
REQ-009 SHALL have port prescale, input, PRESC_W bits: oversampling ratio; legal values 8, 16, 32.
REQ-010 SHALL have port P_DATA, output, DATA_WIDTH bits: received word, LSB first on the line.
REQ-011 SHALL have port data_valid, output, 1 bit: one-cycle pulse marking a good frame.
REQ-012 SHALL have ports par_err, stp_err and strt_glitch, each output, 1 bit: one-cycle error pulses.
REQ-013 SHALL have port break_det, output, 1 bit: one-cycle break pulse.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL use states IDLE, START, DATA, PARITY, STOP1, STOP2, VALID and BREAK.
REQ-016 SHALL capture PAR_EN, PAR_TYP, STOP2 and prescale on the IDLE->START transition and hold them for the frame.
- An illegal prescale SHALL be treated as 8.
REQ-017 SHALL leave IDLE for START in the cycle after rx_in is sampled 0; the edge counter resets to 0 on that transition.
REQ-018 SHALL run the edge counter 0..P-1 within each bit period, where P is the captured prescale, then wrap to 0 and increment the bit counter.
REQ-019 SHALL sample each bit at edge counts P/2-1, P/2 and P/2+1 and take the majority-of-3 value as the bit.
REQ-020 SHALL handle a start bit whose majority value is 1 as follows: pulse strt_glitch and go to IDLE at edge P/2+2.
REQ-021 SHALL shift DATA bits into a shift register LSB first and leave DATA after DATA_WIDTH bit periods.
- Next state is PARITY if PAR_EN, else STOP1.
REQ-022 SHALL compare the PARITY bit against the XOR of the data bits, inverted when PAR_TYP=1.
- A mismatch SHALL set a frame-local parity flag.
REQ-023 SHALL set a frame-local stop flag when STOP1 (or STOP2, when captured STOP2=1) samples 0.
REQ-024 SHALL report results at the final stop bit's edge count P-1:
- No flags: go to VALID, load P_DATA, pulse data_valid in the VALID cycle.
- Otherwise: go to IDLE and pulse par_err and/or stp_err in the same cycle.
- P_DATA SHALL be left unchanged on error.
REQ-025 SHALL exit VALID after exactly one cycle:
- to START when rx_in=0 in that cycle (back-to-back frame, edge counter reset);
- otherwise to IDLE.
REQ-026 SHALL keep every pulse output exactly one cycle wide and never assert data_valid and any error pulse together.

Reset
REQ-027 SHALL, on rst low, asynchronously force state IDLE, all counters 0, the shift register 0, P_DATA 0, all pulse outputs 0 and busy 0.
- This applies mid-frame; no partial frame SHALL be reported after reset is released.

Configuration
REQ-028 SHALL use macro UART_RX_BREAK_DET_EN to select break detection.
- Defined: when stop is sampled 0 and all data bits and any parity bit are 0, pulse break_det in place of stp_err/par_err. Then enter BREAK and hold there until rx_in is sampled 1, then go to IDLE.
- Undefined: the BREAK state is absent, break_det is tied 0, and such frames report stp_err.

Structure
REQ-029 SHALL define the state encoding typedef, the legal prescale constants and the default DATA_WIDTH in shared package uart_rx_pkg.
REQ-030 SHALL place the 3-sample majority voter and edge-position decode in sub-module uart_rx_sampler.

Verification
REQ-031 SHALL cover: prescale=8, PAR_EN=1, PAR_TYP=0, byte 0xA5 with correct parity -> data_valid one cycle, P_DATA=0xA5, no errors.
REQ-032 SHALL cover: same frame with parity bit flipped -> par_err pulse, no data_valid, P_DATA keeps its previous value.
REQ-033 SHALL cover: rx_in low for 3 cycles only at prescale=16 -> strt_glitch pulse, return to IDLE, busy low.
REQ-034 SHALL cover: STOP2=1, prescale=32, second stop bit 0 -> stp_err at the end of STOP2.
REQ-035 SHALL cover: two frames back-to-back (0x3C then 0xC3) with start immediately after the stop bit -> two data_valid pulses, both correct.
REQ-036 SHALL cover: reset asserted mid-DATA -> outputs 0 immediately; the next full frame 0x5A is received correctly.
REQ-037 SHALL cover, with UART_RX_BREAK_DET_EN defined: line held low for 20 bit periods -> single break_det pulse; IDLE is reached only after rx_in returns high.
